// File: rtl/hdl_pkg.sv
// Shared definitions for the register / serializer data path.
//   WORD_W  : default word width, also used by the word-wide register
//   state_e : serializer state encoding
package hdl_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : hdl_pkg

// File: rtl/bit_counter.sv
// Parameterized down-counter with synchronous load, count enable and zero flag.
//   clk      : clock
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val at the next rising edge (has priority over en)
//   load_val : value to load
//   en       : decrement at the next rising edge
//   cnt      : current count (registered)
//   zero_c   : combinational flag, cnt == 0
module bit_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    // Count register; the owner never enables a decrement at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule : bit_counter

// File: rtl/serializer.sv
// Parallel-in, serial-out shifter: emits an N-bit word MSB first, one bit per
// clock, framed by valid/last, with consumer back-pressure via stall.
//   clk   : clock
//   rst_n : asynchronous active-low reset, drops any word in flight
//   in    : parallel word, sampled only when a load is accepted
//   load  : load request, honoured only while ready is high
//   stall : freezes the shifter while high (no effect in IDLE)
//   ready : word can be accepted at the next rising edge (combinational)
//   out   : current serial bit
//   valid : out carries a data bit
//   last  : out is bit 0 of the word (combinational)
module serializer
    import hdl_pkg::*;
#(
    parameter int unsigned N = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         load,
    input  logic         stall,
    output logic         ready,
    output logic         out,
    output logic         valid,
    output logic         last
);

    localparam int unsigned CW = $clog2(N);

    state_e          state_q;
    state_e          state_d;
    logic [N-1:0]    sr_q;
    logic [N-1:0]    sr_d;
    logic [CW-1:0]   cnt;
    logic            cnt_zero_c;
    logic            cnt_load_c;
    logic            cnt_en_c;

    // Bits remaining after the one currently on out.
    bit_counter #(
        .W (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (CW'(N - 1)),
        .en       (cnt_en_c),
        .cnt      (cnt),
        .zero_c   (cnt_zero_c)
    );

    // State and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
        end
    end

    // Next state and datapath control; stall in SHIFT holds everything.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_load_c = 1'b0;
        cnt_en_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = SHIFT;
                    sr_d       = in;
                    cnt_load_c = 1'b1;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    if (!cnt_zero_c) begin
                        sr_d     = {sr_q[N-2:0], 1'b0};
                        cnt_en_c = 1'b1;
                    end else if (load) begin
                        // Back-to-back word: no gap in valid.
                        sr_d       = in;
                        cnt_load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sr_d    = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid = (state_q == SHIFT);
    assign out   = sr_q[N-1];
    assign last  = valid & cnt_zero_c;
    // A stalled last bit cannot be retired, so no new word can enter.
    assign ready = (state_q == IDLE) | (last & ~stall);

endmodule : serializer

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: accepted words push their expected
// (out, last) stream; monitors pop and compare whenever valid is high.
module tb_serializer;

    logic        clk;
    logic        rst_n;
    logic [31:0] in;
    logic        load;
    logic        stall;
    logic        ready;
    logic        out;
    logic        valid;
    logic        last;

    logic [1:0]  in2;
    logic        load2;
    logic        stall2;
    logic        ready2;
    logic        out2;
    logic        valid2;
    logic        last2;

    int vectors;
    int miscompares;
    int vcount;

    logic [1:0] q[$];   // {out, last}
    logic [1:0] q2[$];

    serializer #(.N(32)) d32 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .stall (stall),
        .ready (ready),
        .out   (out),
        .valid (valid),
        .last  (last)
    );

    serializer #(.N(2)) d2 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in2),
        .load  (load2),
        .stall (stall2),
        .ready (ready2),
        .out   (out2),
        .valid (valid2),
        .last  (last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a word for the coming edge; expected bits go to the scoreboard.
    task automatic load_word(input logic [31:0] w);
        #1;
        chk1("ready_at_load", ready, 1'b1);
        in   = w;
        load = 1'b1;
        for (int i = 31; i >= 0; i--) q.push_back({w[i], (i == 0)});
        tick();
        load = 1'b0;
        in   = '0;
    endtask

    // Monitor for the 32-bit instance: a stalled bit is checked but kept.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcount++;
            if (q.size() == 0) begin
                chk1("unexpected_valid", valid, 1'b0);
            end else begin
                chk1("out", out, q[0][1]);
                chk1("last", last, q[0][0]);
                if (!stall) void'(q.pop_front());
            end
        end
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        if (valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk1("n2_unexpected_valid", valid2, 1'b0);
            end else begin
                chk1("n2_out", out2, q2[0][1]);
                chk1("n2_last", last2, q2[0][0]);
                if (!stall2) void'(q2.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        vcount      = 0;
        rst_n  = 1'b0;
        in     = '0;
        load   = 1'b0;
        stall  = 1'b0;
        in2    = '0;
        load2  = 1'b0;
        stall2 = 1'b0;

        // Reset values.
        #2;
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_out", out, 1'b0);
        chk1("rst_last", last, 1'b0);
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_valid_n2", valid2, 1'b0);

        // Single word, loaded on the first edge after reset release.
        #9;
        rst_n  = 1'b1;
        vcount = 0;
        load_word(32'hFFFF_AAAA);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            chk1("single_ready", ready, (c == 32));
            tick();
        end
        @(negedge clk);
        chk1("single_idle_valid", valid, 1'b0);
        chk1("single_idle_ready", ready, 1'b1);
        tick();
        chk32("single_valid_cycles", vcount, 32);
        chk32("single_q_empty", q.size(), 0);

        // Back-to-back: second word loaded on the last cycle of the first.
        vcount = 0;
        load_word(32'hFFFF_AAAA);
        ticks(31);
        chk1("b2b_last", last, 1'b1);
        load_word(32'h0000_0001);
        ticks(32);
        @(negedge clk);
        chk1("b2b_idle", valid, 1'b0);
        tick();
        chk32("b2b_valid_cycles", vcount, 64);
        chk32("b2b_q_empty", q.size(), 0);

        // Stall for 3 cycles on bit 20.
        vcount = 0;
        load_word(32'hFFFF_AAAA);
        ticks(11);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk32("stall_cnt", int'(d32.cnt), 20);
            chk1("stall_ready", ready, 1'b0);
            tick();
        end
        chk32("stall_cnt_after", int'(d32.cnt), 20);
        stall = 1'b0;
        ticks(21);
        @(negedge clk);
        chk1("stall_idle", valid, 1'b0);
        tick();
        chk32("stall_valid_cycles", vcount, 35);
        chk32("stall_q_empty", q.size(), 0);

        // Load and stall together on the last bit: load refused, bit held.
        load_word(32'hFFFF_AAAA);
        ticks(31);
        stall = 1'b1;
        load  = 1'b1;
        in    = 32'h1234_5678;
        #1;
        chk1("stall_last_ready", ready, 1'b0);
        tick();
        chk1("stall_last_held", last, 1'b1);
        stall = 1'b0;
        load  = 1'b0;
        in    = '0;
        tick();
        @(negedge clk);
        chk1("stall_last_idle", valid, 1'b0);
        tick();
        chk32("stall_last_q_empty", q.size(), 0);

        // Load pulse mid-word is ignored.
        load_word(32'hFFFF_AAAA);
        ticks(21);
        in   = 32'h0;
        load = 1'b1;
        #1;
        chk1("ignored_ready", ready, 1'b0);
        tick();
        load = 1'b0;
        ticks(10);
        @(negedge clk);
        chk1("ignored_idle", valid, 1'b0);
        tick();
        chk32("ignored_q_empty", q.size(), 0);

        // Asynchronous reset between edges after 5 bits.
        load_word(32'hFFFF_AAAA);
        ticks(4);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk1("arst_valid", valid, 1'b0);
        chk1("arst_out", out, 1'b0);
        chk1("arst_last", last, 1'b0);
        chk1("arst_ready", ready, 1'b1);
        tick();
        rst_n  = 1'b1;
        vcount = 0;
        load_word(32'h0000_0001);
        ticks(32);
        @(negedge clk);
        chk1("arst_reload_idle", valid, 1'b0);
        tick();
        chk32("arst_valid_cycles", vcount, 32);
        chk32("arst_q_empty", q.size(), 0);

        // Minimum width: N=2, word 2'b10.
        #1;
        chk1("n2_ready", ready2, 1'b1);
        in2   = 2'b10;
        load2 = 1'b1;
        q2.push_back({1'b1, 1'b0});
        q2.push_back({1'b0, 1'b1});
        tick();
        load2 = 1'b0;
        in2   = '0;
        @(negedge clk);
        chk1("n2_valid1", valid2, 1'b1);
        chk1("n2_ready1", ready2, 1'b0);
        tick();
        @(negedge clk);
        chk1("n2_last2", last2, 1'b1);
        chk1("n2_ready2", ready2, 1'b1);
        tick();
        @(negedge clk);
        chk1("n2_idle", valid2, 1'b0);
        chk32("n2_q_empty", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serializer
